// File: rtl/or_gate_exerciser_if.sv
// Gate-side connection between the exerciser and a 2-input OR gate under test.
interface or_gate_exerciser_if;
  logic a_out;
  logic b_out;
  logic c_in;

  modport master (output a_out, output b_out, input c_in);
  modport slave  (input a_out, input b_out, output c_in);
endinterface

// File: rtl/or_gate_exerciser.sv
// Drives the four {a,b} vectors into a 2-input OR gate, checks c against a|b,
// and reports per-vector failures, a saturating error count and a pass flag.
module or_gate_exerciser #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  or_gate_exerciser_if.master gate,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [3:0]          fail_vec
);

  localparam int unsigned CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  state_t           state;
  logic [1:0]       vec;
  logic [CNT_W-1:0] cnt;

  logic       mismatch;
  logic [3:0] fail_next;
  logic [1:0] vec_inc;

  // Compare result for the vector currently applied, and the failure map it would produce.
  always_comb begin
    mismatch  = (gate.c_in != (vec[1] | vec[0]));
    fail_next = mismatch ? (fail_vec | (4'd1 << vec)) : fail_vec;
    vec_inc   = vec + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      gate.a_out <= 1'b0;
      gate.b_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= DRIVE;
            busy       <= 1'b1;
            vec        <= '0;
            cnt        <= '0;
            gate.a_out <= 1'b0;
            gate.b_out <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
          end
        end
        DRIVE: begin
          if (cnt == CNT_W'(SETTLE)) begin
            // End of the hold window: score this vector, then advance or finish.
            if (mismatch) begin
              fail_vec <= fail_next;
              if (err_count != '1) begin
                err_count <= err_count + ERR_W'(1);
              end
            end
            cnt <= '0;
            if (vec == 2'd3) begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= (fail_next == 4'd0);
              vec        <= '0;
              gate.a_out <= 1'b0;
              gate.b_out <= 1'b0;
            end else begin
              vec        <= vec_inc;
              gate.a_out <= vec_inc[1];
              gate.b_out <= vec_inc[0];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
